fetch_sequencer: RTL
====================

# fetch_sequencer

Instruction fetch controller for the 4-entry program ROM. It owns the program counter and drives the ROM address. It latches each 8-bit instruction and presents it to the execute stage over a valid/ready handshake. It also applies branch redirects from the execute stage and stops on a HALT opcode. It sits between the combinational program ROM and the execute/ALU stage of the microprocessor.

## Interface
- ADDR_WIDTH, 2, ROM address width; PC wraps modulo 2^ADDR_WIDTH
- DATA_WIDTH, 8, instruction width; opcode is the upper 4 bits
- HALT_OPCODE, 4'h4, opcode value that stops sequencing
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  reset; asynchronous assert, active-low
- start  input  1  one-cycle pulse; leaves IDLE or HALTED, ignored elsewhere
- rom_addr  output  ADDR_WIDTH  address to ROM; always equals pc
- rom_data  input  DATA_WIDTH  combinational ROM read data for rom_addr
- instr  output  DATA_WIDTH  latched instruction
- instr_valid  output  1  instr is presented to execute stage
- instr_ready  input  1  execute stage accepts instr
- redirect_valid  input  1  branch taken; sampled only on the handshake cycle
- redirect_addr  input  ADDR_WIDTH  branch target
- pc  output  ADDR_WIDTH  current program counter
- busy  output  1  high in FETCH or ISSUE
- halted  output  1  high in HALTED

## Operation
- States:
  - IDLE: reset state.
  - FETCH: rom_addr=pc; rom_data is captured into instr at the clock edge, then go to ISSUE.
  - ISSUE: instr_valid=1; instr is held stable until instr_ready=1.
  - HALTED.
- IDLE, start=1: pc←0, go to FETCH.
- HALTED, start=1: pc←0, go to FETCH.
- ISSUE with instr_ready=1 (handshake):
  - instr[7:4]==HALT_OPCODE: go to HALTED; pc unchanged; redirect ignored.
  - redirect_valid=1: pc←redirect_addr, go to FETCH.
  - otherwise: pc←pc+1, truncated to ADDR_WIDTH (3→0 wraps), go to FETCH.
- ISSUE with instr_ready=0: stay in ISSUE; pc and instr hold; redirect_valid is ignored.
- start asserted in FETCH or ISSUE has no effect.
- instr holds its last value in IDLE and HALTED.
- Reset mid-operation (any state):
  - Immediate return to IDLE.
  - Outputs go to reset values without waiting for clk.
  - Any pending issue is dropped.
- Reset values:
  - pc=0, rom_addr=0, instr=0.
  - instr_valid=0, busy=0, halted=0.

## Timing
- Fetch-to-issue latency: 1 cycle. The FETCH cycle is followed by ISSUE in the next cycle.
- Best-case throughput with instr_ready held high: one instruction per 2 cycles (FETCH, ISSUE alternate).
- start→first instr_valid: 2 cycles (state IDLE→FETCH→ISSUE).
- Redirect takes effect on the next FETCH with no extra bubble. No instruction from the old path is ever issued.
- instr_valid, busy and halted are registered state decodes. rom_addr is a direct copy of the pc register.

## Configuration
- SEQ_SINGLE_STEP_EN.
- Defined: adds ports step_mode (input, 1) and step (input, 1).
  - When step_mode=1, FETCH waits: the sequencer leaves FETCH only in a cycle with step=1, and stays in FETCH otherwise.
  - When step_mode=0, behaviour is identical to the undefined build.
  - busy stays high while waiting in FETCH.
- Undefined: the ports are absent; FETCH always completes in one cycle.

## Test plan
All scenarios use ROM = {0:8'h10, 1:8'h30, 2:8'h40, 3:8'h40}.
- Reset then start, instr_ready=1: instr=8'h10 valid in cycle 2, then 8'h30 in cycle 4, then 8'h40 in cycle 6. After that handshake halted=1, pc=2, instr_valid=0.
- Backpressure, instr_ready=0 for 5 cycles during ISSUE of 8'h30: instr_valid and instr=8'h30 hold, pc=1 holds. On release, exactly one handshake occurs and pc→2.
- Redirect on the 8'h10 handshake to redirect_addr=1: next instr=8'h30. Redirect asserted while instr_ready=0 does not change pc.
- Wrap, ROM[3] changed to 8'h20 with redirect to 3: after the 8'h20 handshake pc=0 and next instr=8'h10.
- HALTED then start: pc=0 and sequencing restarts with 8'h10. start pulsed during ISSUE: no change.
- rst_n pulled low mid-ISSUE between clock edges: instr_valid=0, pc=0 and instr=0 immediately. The sequencer stays in IDLE until start.
- Single step, SEQ_SINGLE_STEP_EN defined, step_mode=1: no instr_valid until step=1. Each step pulse yields exactly one instruction.

Source files
------------

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// fetch_sequencer : PC owner and fetch/issue controller for the program ROM.
//   Optional single-step gating of FETCH under macro SEQ_SINGLE_STEP_EN.
// Revision: 1.0  initial release
// ============================================================================
module fetch_sequencer #(
  parameter int         ADDR_WIDTH  = 2,
  parameter int         DATA_WIDTH  = 8,
  parameter logic [3:0] HALT_OPCODE = 4'h4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic                  step_mode,
  input  logic                  step,
`endif
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [DATA_WIDTH-1:0] instr,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  busy,
  output logic                  halted
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_ISSUE  = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_instr;
  logic                  r_valid;
  logic                  r_busy;
  logic                  r_halted;
  logic                  w_fetch_go;
  logic                  w_is_halt;

`ifdef SEQ_SINGLE_STEP_EN
  assign w_fetch_go = !step_mode || step;
`else
  assign w_fetch_go = 1'b1;
`endif

  assign w_is_halt = (r_instr[DATA_WIDTH-1 -: 4] == HALT_OPCODE);

  // Status outputs are loaded together with the next state so they are pure flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_pc     <= '0;
      r_instr  <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_HALTED: begin
          if (start) begin
            r_pc     <= '0;
            r_state  <= S_FETCH;
            r_busy   <= 1'b1;
            r_halted <= 1'b0;
          end
        end
        S_FETCH: begin
          if (w_fetch_go) begin
            r_instr <= rom_data;
            r_state <= S_ISSUE;
            r_valid <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (instr_ready) begin
            r_valid <= 1'b0;
            if (w_is_halt) begin
              r_state  <= S_HALTED;
              r_busy   <= 1'b0;
              r_halted <= 1'b1;
            end else begin
              r_pc    <= redirect_valid ? redirect_addr : r_pc + 1'b1;
              r_state <= S_FETCH;
            end
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_valid  <= 1'b0;
          r_busy   <= 1'b0;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  assign rom_addr    = r_pc;
  assign pc          = r_pc;
  assign instr       = r_instr;
  assign instr_valid = r_valid;
  assign busy        = r_busy;
  assign halted      = r_halted;

endmodule
`default_nettype wire
